priority_request_encoder: RTL

Parametrised, registered successor to the team's 4-input priority encoder. Collects one-cycle request pulses from N sources into a pending vector. Presents the winning source index on a valid/ready output port, in either fixed-priority or round-robin order. Sits between interrupt/event sources and a single consumer (controller FSM or arbiter), so that pulsed requests are never lost.

---
 rtl/priority_request_encoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/priority_request_encoder.sv
// -----------------------------------------------------------------------------
// priority_request_encoder
//
// Collects one-cycle request pulses from N sources into a pending vector and
// presents one winning source index at a time on a valid/ready port.
// Requests are never lost. A repeat request from a source that is already
// pending is merged into the existing one, and req_drop is pulsed.
//
// Selection order:
//   RR_MODE = 0 : fixed priority, highest set index wins.
//   RR_MODE = 1 : round-robin. The last granted source has the lowest
//                 priority. The search runs downward from ptr-1 and wraps
//                 modulo N.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_in     [N-1:0] request pulses, OR-ed into pending
//   out_ready  consumer accepts the presented index this cycle
//   out_valid  out_idx holds a pending request
//   out_idx    [IDXW-1:0] selected source, 0 when out_valid = 0
//   pending    [N-1:0] unserved requests, including the presented one
//   pend_cnt   [IDXW:0] population count of pending
//   req_drop   one-cycle pulse when a request was merged into a pending bit
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module priority_request_encoder #(
    parameter int N       = 8,
    parameter int IDXW    = (N > 1) ? $clog2(N) : 1,
    parameter int RR_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    pending,
    output logic [IDXW:0]   pend_cnt,
    output logic            req_drop
);

    logic [N-1:0]    pending_reg;
    logic [N-1:0]    pending_next;
    logic [N-1:0]    pop_mask;
    logic            pop;
    logic            out_valid_reg;
    logic [IDXW-1:0] out_idx_reg;
    logic [IDXW-1:0] sel_idx;
    logic [IDXW:0]   pend_cnt_reg;
    logic [IDXW:0]   cnt_next;
    logic            req_drop_reg;

    assign pop = out_valid_reg & out_ready;

    // One-hot clear mask for the index that is handed off this cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pop_mask
            assign pop_mask[gi] = pop && (out_idx_reg == IDXW'(gi));
        end
    endgenerate

    // A source that is popped and re-requested in the same cycle stays set.
    assign pending_next = (pending_reg & ~pop_mask) | req_in;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next = cnt_next + (IDXW+1)'(pending_next[i]);
        end
    end

    generate
        if (RR_MODE != 0) begin : g_rr
            logic [IDXW-1:0] ptr_reg;
            logic [IDXW-1:0] ptr_next;

            // The selection sees the pointer as updated by this cycle's pop.
            // Without that, the source just granted could win again at once.
            assign ptr_next = pop ? out_idx_reg : ptr_reg;

            always_comb begin
                logic [IDXW-1:0] cand;
                logic            found;
                sel_idx = '0;
                found   = 1'b0;
                // Candidates are ptr-1, ptr-2, ..., ptr, taken modulo N
                // (not modulo 2^IDXW). Indices >= N are never produced.
                for (int s = 1; s <= N; s++) begin
                    cand = IDXW'((int'(ptr_next) + N - s) % N);
                    if (!found && pending_next[cand]) begin
                        sel_idx = cand;
                        found   = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_reg <= '0;
                end else begin
                    ptr_reg <= ptr_next;
                end
            end
        end else begin : g_fixed
            // The last assignment wins, so the highest set index is selected.
            always_comb begin
                sel_idx = '0;
                for (int i = 0; i < N; i++) begin
                    if (pending_next[i]) begin
                        sel_idx = IDXW'(i);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg   <= '0;
            pend_cnt_reg  <= '0;
            req_drop_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
        end else begin
            pending_reg  <= pending_next;
            pend_cnt_reg <= cnt_next;
            req_drop_reg <= |(req_in & pending_reg & ~pop_mask);
            // While a presented index is stalled, it stays put. A newer
            // higher-priority arrival is only recorded in pending.
            if (!out_valid_reg || out_ready) begin
                out_valid_reg <= |pending_next;
                out_idx_reg   <= sel_idx;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign pending   = pending_reg;
    assign pend_cnt  = pend_cnt_reg;
    assign req_drop  = req_drop_reg;

endmodule
